// File: rtl/mux_4_arbiter.sv
// mux_4_arbiter: round-robin, hold-limited arbiter that owns the mux_4 select and registers the granted beat
//   clk, rst_n               : clock, asynchronous active-low reset
//   req[3:0]                 : requests, bit0=a .. bit3=d
//   data_a..data_d           : requester data
//   gnt, sel                 : registered one-hot grant and matching mux select
//   out_data, out_valid      : registered data stream of the granted requester
//   busy                     : registered, high while a grant is held
module mux_4_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, scan, win;
  logic [3:0]       cnt_q, cnt_d, gnt_q, gnt_d;
  logic [WIDTH-1:0] od_q, od_d, own_data;
  logic             ov_q, ov_d, busy_q, busy_d, own_req, rel;
  always_comb begin
    own_data = sel_q == 2'd0 ? data_a : sel_q == 2'd1 ? data_b : sel_q == 2'd2 ? data_c : data_d;
    own_req  = req[sel_q];
    rel      = state_q == GRANT && (!own_req || cnt_q == 4'(HOLD_MAX));
    // a release re-arbitrates at the same edge starting just past the old owner
    scan     = rel ? sel_q + 2'd1 : ptr_q;
    win      = scan;
    for (int i = 3; i >= 0; i--)
      if (req[scan + 2'(i)]) win = scan + 2'(i);
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ov_d    = state_q == GRANT && own_req;
    od_d    = ov_d ? own_data : od_q;
    if (state_q == IDLE || rel) begin
      if (rel) ptr_d = scan;
      if (|req) begin
        state_d = GRANT;
        gnt_d   = 4'b0001 << win;
        sel_d   = win;
        cnt_d   = 4'd1;
        busy_d  = 1'b1;
      end else if (rel) begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_data  = od_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mux_4_arbiter.sv
// tb_mux_4_arbiter: scoreboard bench for hold limits 4 and 1 driven by the same requests
module tb_mux_4_arbiter;
  logic       clk = 0, rst_n = 1;
  logic [3:0] req = 0, data_a = 0, data_b = 0, data_c = 0, data_d = 0;
  logic [3:0] g4, g1, d4, d1;
  logic [1:0] s4, s1;
  logic       v4, v1, b4, b1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int st, ptr, cnt, gnt, sel, od, ov, busy;} mdl_t;
  typedef struct {mdl_t a; mdl_t b;} exp_t;
  exp_t sb[$];
  mdl_t m4, m1, rst_m;
  mux_4_arbiter #(.WIDTH(4), .HOLD_MAX(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .data_d(data_d), .gnt(g4), .sel(s4), .out_data(d4), .out_valid(v4), .busy(b4));
  mux_4_arbiter #(.WIDTH(4), .HOLD_MAX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .data_d(data_d), .gnt(g1), .sel(s1), .out_data(d1), .out_valid(v1), .busy(b1));
  always #5 clk = ~clk;
  function automatic mdl_t nxt(input mdl_t m, input int hm, input logic [3:0] r, input logic [15:0] dv);
    mdl_t n = m;
    int own = m.sel;
    int w = -1;
    if (m.st == 1) begin
      n.ov = int'(r[own]);
      if (r[own]) n.od = int'(dv[own*4 +: 4]);
      if (r[own] && m.cnt < hm) begin
        n.cnt = m.cnt + 1;
        return n;
      end
      n.ptr = (own + 1) % 4;
    end else n.ov = 0;
    for (int k = 0; k < 4 && w < 0; k++)
      if (r[(n.ptr + k) % 4]) w = (n.ptr + k) % 4;
    if (w >= 0) begin
      n.st = 1; n.gnt = 1 << w; n.sel = w; n.cnt = 1; n.busy = 1;
    end else if (m.st == 1) begin
      n.st = 0; n.gnt = 0; n.busy = 0; n.cnt = 0;
    end
    return n;
  endfunction
  task automatic chk(input string t, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", t, act, exp);
    end
  endtask
  task automatic cmp(input string p, input mdl_t e, input int g, input int s, input int od, input int ov, input int b);
    chk({p, "_gnt"}, g, e.gnt);
    chk({p, "_sel"}, s, e.sel);
    chk({p, "_out_data"}, od, e.od);
    chk({p, "_out_valid"}, ov, e.ov);
    chk({p, "_busy"}, b, e.busy);
  endtask
  task automatic cyc();
    exp_t e;
    e.a = nxt(m4, 4, req, {data_d, data_c, data_b, data_a});
    e.b = nxt(m1, 1, req, {data_d, data_c, data_b, data_a});
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    m4 = e.a;
    m1 = e.b;
    cmp("h4", m4, int'(g4), int'(s4), int'(d4), int'(v4), int'(b4));
    cmp("h1", m1, int'(g1), int'(s1), int'(d1), int'(v1), int'(b1));
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_gnt", int'(g4), 0);
    chk("rst_busy", int'(b4), 0);
    rst_n = 1;
    m4 = rst_m;
    m1 = rst_m;
  endtask
  initial begin
    rst_m = '{default: 0};
    m4 = rst_m;
    m1 = rst_m;
    req = 4'hf;
    data_a = 0; data_b = 1; data_c = 2; data_d = 3;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rst_gnt", int'(g4), 0);
    chk("t1_rst_ov", int'(v4), 0);
    chk("t1_rst_busy", int'(b4), 0);
    rst_n = 1;
    cyc();
    chk("t1_gnt", int'(g4), 1);
    chk("t1_sel", int'(s4), 0);
    cyc();
    chk("t1_ov", int'(v4), 1);
    for (int j = 2; j < 20; j++) begin
      cyc();
      chk("t2_gnt", int'(g4), 1 << ((j / 4) % 4));
      chk("t2_od", int'(d4), ((j - 1) / 4) % 4);
      chk("t2_ov", int'(v4), 1);
    end
    req = 4'b0100;
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk("t3_gnt", int'(g4), 4);
      chk("t3_sel", int'(s4), 2);
      if (j > 0) chk("t3_od", int'(d4), 2);
      if (j > 0) chk("t3_ov", int'(v4), 1);
    end
    do_reset();
    req = 4'b1001;
    cyc();
    cyc();
    req = 4'b1000;
    cyc();
    chk("t4_gnt", int'(g4), 8);
    chk("t4_sel", int'(s4), 3);
    chk("t4_ov", int'(v4), 0);
    cyc();
    chk("t4_ov2", int'(v4), 1);
    chk("t4_od", int'(d4), 3);
    do_reset();
    req = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("t5_gnt", int'(g1), (j % 2) != 0 ? 8 : 2);
    end
    req = 4'b0100;
    repeat (3) cyc();
    chk("t6_pre_gnt", int'(g4), 4);
    #2 rst_n = 0;
    #1;
    chk("t6_gnt", int'(g4), 0);
    chk("t6_ov", int'(v4), 0);
    chk("t6_busy", int'(b4), 0);
    chk("t6_gnt_h1", int'(g1), 0);
    m4 = rst_m;
    m1 = rst_m;
    #1 rst_n = 1;
    req = 4'hf;
    cyc();
    chk("t6_regrant", int'(g4), 1);
    repeat (400) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      data_a = 4'($urandom); data_b = 4'($urandom);
      data_c = 4'($urandom); data_d = 4'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_4_arbiter.md
Name: mux_4_arbiter

Overview:
Round-robin arbiter and sequencer that shares the 4-input mux_4 datapath between four requesters (a, b, c, d). It drives the mux select and one-hot grants, and limits each grant to at most HOLD_MAX consecutive cycles. It registers the selected requester's data into a valid-qualified output stream. The block sits in front of mux_4 and owns its sel input.

Parameters:
WIDTH, 4, data width of each requester input and of out_data.
HOLD_MAX, 4, maximum consecutive granted cycles per grant; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request vector; bit0=a, bit1=b, bit2=c, bit3=d.
data_a  input  WIDTH  requester a data.
data_b  input  WIDTH  requester b data.
data_c  input  WIDTH  requester c data.
data_d  input  WIDTH  requester d data.
gnt  output  4  registered one-hot grant; 0000 when idle.
sel  output  2  registered mux select; equals the index of the set gnt bit.
out_data  output  WIDTH  registered data of the granted requester.
out_valid  output  1  registered; high when out_data carries a granted requester's beat.
busy  output  1  registered; high while in GRANT.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst_n is asynchronous and active-low.
  - Asserting rst_n=0 immediately, without a clock edge, forces: gnt=0000, sel=00, out_data=0, out_valid=0, busy=0, state=IDLE, ptr=0, cnt=0.
  - Deassertion is sampled on the next rising clk edge.
- State machine, states IDLE and GRANT:
  - IDLE:
    - If req==0000, stay in IDLE.
    - Otherwise, at the edge, pick a winner by round-robin scan from ptr upward with wrap (ptr, ptr+1, ..., ptr+3 mod 4).
    - Set gnt=one-hot(winner), sel=winner, cnt=1, busy=1, and go to GRANT.
  - GRANT (owner = sel):
    - Release condition: req[owner]==0 OR cnt==HOLD_MAX.
    - Without release: stay in GRANT, cnt<=cnt+1.
    - On release: ptr<=owner+1 (mod 4), then re-arbitrate at the same edge using the new ptr.
    - If a winner exists, grant it with cnt=1 and no idle bubble. This may be the same owner if it is the only requester.
    - If no requester: go to IDLE, gnt=0000, busy=0. sel holds its last value.
- Grant latency: a request sampled at edge k is granted at the earliest from edge k (visible in cycle k+1).
- Output path, evaluated at every edge while in GRANT:
  - out_valid <= req[owner].
  - If req[owner]==1, out_data <= data of owner (data_a..data_d per sel). Otherwise out_data holds.
  - In IDLE: out_valid<=0 and out_data holds.
  - Data latency is one cycle after the granted cycle.
- Fairness: a continuously requesting port waits at most 3*HOLD_MAX cycles for a grant.
- Boundary conditions:
  - req[owner] drops in the same cycle that cnt==HOLD_MAX: a single release; ptr advances once.
  - HOLD_MAX=1: grants rotate every cycle among the active requesters.
  - Wrap: owner=3 sets ptr=0.
  - Requests arriving in the same cycle as a release are visible to that same-edge arbitration.
  - Reset mid-grant: the grant is aborted immediately; after reset, arbitration restarts with ptr=0.
  - cnt is 4 bits wide and never exceeds HOLD_MAX.

Test Plan:
1. rst_n=0 with req=1111 and a running clock -> gnt=0000, out_valid=0, busy=0. Release rst_n -> at the first edge gnt=0001, sel=00; out_valid=1 one cycle later.
2. HOLD_MAX=4, req=1111 held constant, data_a=0, data_b=1, data_c=2, data_d=3 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. out_data is 0 x4, 1 x4, 2 x4, 3 x4 lagging one cycle; out_valid stays continuously 1.
3. Only req[2]=1 for 10 cycles -> gnt=0100 and sel=10 continuously (re-grant at each HOLD_MAX expiry with no gap). out_data=2 and out_valid=1 on every cycle from the second cycle on.
4. req=1001 with a granted; drop req[0] after 2 granted cycles -> next edge gnt=1000, sel=11. out_valid=0 for exactly one cycle, then out_data=3.
5. HOLD_MAX=1, req=1010 -> gnt alternates 0010, 1000, 0010 ... every cycle. After the owner=3 grant, ptr wraps to 0 and bit 1 wins next.
6. Pulse rst_n low mid-cycle during a grant to c -> gnt, out_valid and busy go to 0 before the next clk edge. After release, with req=1111, the first grant is gnt=0001.
